// File: rtl/shift_pkg.sv
// Shared state encodings and reset constants for the serial deserializer.
// No logic; types and constants only.
// Imported by every file of the deserializer.
package shift_pkg;

   // Deserializer FSM: IDLE when no bits of a word are held, SHIFT otherwise
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Value loaded into the shifter and the output buffer on reset
   localparam logic [31:0] RESET_WORD = 32'd0;

endpackage

// File: rtl/deser_out_buf.sv
// Single-entry valid/ready holding register for assembled words, with sticky overrun.
// Latency: a loaded word is visible on dout/dout_valid the cycle after its load strobe.
// Backpressure: a load while full and not being drained drops the new word and sets overrun.
module deser_out_buf
   import shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             R,
   input  logic             load,
   input  logic [WIDTH-1:0] word,
   input  logic             dout_ready,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             overrun
);

   logic [WIDTH-1:0] dout_q, dout_d;
   logic             vld_q, vld_d;
   logic             ovr_q, ovr_d;

   // Next-state: load if the slot is free or being drained, else drop; otherwise consume
   always_comb begin
      dout_d = dout_q;
      vld_d  = vld_q;
      ovr_d  = ovr_q;
      if (load) begin
         if (!vld_q || dout_ready) begin
            dout_d = word;
            vld_d  = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (vld_q && dout_ready) begin
         vld_d = 1'b0;
      end
   end

   // Buffer registers; overrun is cleared only by reset
   always_ff @(posedge clk) begin
      if (R) begin
         dout_q <= RESET_WORD[WIDTH-1:0];
         vld_q  <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         dout_q <= dout_d;
         vld_q  <= vld_d;
         ovr_q  <= ovr_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = vld_q;
   assign overrun    = ovr_q;

endmodule

// File: rtl/serial_deserializer.sv
// Bit-serial to WIDTH-bit parallel deserializer with sof resync and a one-word output buffer.
// Latency: word visible on dout one clk after the edge that captures its last bit.
// Backpressure: none toward the serial side; words completing into a stalled buffer are dropped (overrun).
module serial_deserializer
   import shift_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             R,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             sof,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overrun,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] sh_q, sh_d, base_sh, next_sh;
   logic [CW-1:0]    cnt_q, cnt_d, base_cnt;
   state_t           st_q, st_d;
   logic             load;

   // Shift direction selected at elaboration; a 1-bit word is just the incoming bit
   generate
      if (WIDTH == 1) begin : g_w1
         assign next_sh = sin;
      end else if (MSB_FIRST) begin : g_msb
         assign next_sh = {base_sh[WIDTH-2:0], sin};
      end else begin : g_lsb
         assign next_sh = {sin, base_sh[WIDTH-1:1]};
      end
   endgenerate

   // Next-state: sof restarts the word, the WIDTH-th bit completes it and loads the buffer
   always_comb begin
      base_sh  = sof ? RESET_WORD[WIDTH-1:0] : sh_q;
      base_cnt = sof ? '0 : cnt_q;
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      st_d     = st_q;
      load     = 1'b0;
      if (sin_valid) begin
         sh_d = next_sh;
         if (base_cnt == CW'(WIDTH - 1)) begin
            cnt_d = '0;
            st_d  = ST_IDLE;
            load  = 1'b1;
         end else begin
            cnt_d = base_cnt + CW'(1);
            st_d  = ST_SHIFT;
         end
      end
   end

   // FSM, bit counter and shifter registers; reset discards any partial word
   always_ff @(posedge clk) begin
      if (R) begin
         st_q  <= ST_IDLE;
         sh_q  <= RESET_WORD[WIDTH-1:0];
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
      end
   end

   assign busy = (st_q == ST_SHIFT);

   deser_out_buf #(
      .WIDTH(WIDTH)
   ) u_out_buf (
      .clk        (clk),
      .R          (R),
      .load       (load),
      .word       (next_sh),
      .dout_ready (dout_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .overrun    (overrun)
   );

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench: MSB-first and LSB-first instances share one serial stream.
// A behavioural model predicts buffer state and pushes expected words to scoreboards.
// Words are popped and compared as the consumer accepts them.
module tb_serial_deserializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       R, sin, sin_valid, sof, dout_ready;
   logic [3:0] dout1, dout0;
   logic       v1, v0, o1, o0, b1, b0;

   serial_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .R(R), .sin(sin), .sin_valid(sin_valid), .sof(sof),
      .dout(dout1), .dout_valid(v1), .dout_ready(dout_ready),
      .overrun(o1), .busy(b1)
   );

   serial_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .R(R), .sin(sin), .sin_valid(sin_valid), .sof(sof),
      .dout(dout0), .dout_valid(v0), .dout_ready(dout_ready),
      .overrun(o0), .busy(b0)
   );

   int n_chk  = 0;
   int n_pass = 0;

   logic [3:0] q1[$];
   logic [3:0] q0[$];

   // behavioural model state
   int         m_cnt;
   logic [3:0] m_bits;
   logic       m_vld, m_ovr;
   logic [3:0] m_d1, m_d0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Model update using the inputs present at the edge just taken
   task automatic model_step();
      logic       done;
      logic [3:0] w1, w0;
      done = 1'b0;
      w1 = '0;
      w0 = '0;
      if (R) begin
         m_cnt = 0; m_bits = '0; m_vld = 1'b0; m_ovr = 1'b0;
         m_d1 = '0; m_d0 = '0;
         q1.delete(); q0.delete();
      end else begin
         if (sin_valid) begin
            if (sof) m_cnt = 0;
            m_bits[m_cnt] = sin;
            m_cnt++;
            if (m_cnt == 4) begin
               done  = 1'b1;
               m_cnt = 0;
               for (int i = 0; i < 4; i++) begin
                  w1[3-i] = m_bits[i];
                  w0[i]   = m_bits[i];
               end
            end
         end
         if (done) begin
            if (!m_vld || dout_ready) begin
               m_d1 = w1; m_d0 = w0; m_vld = 1'b1;
               q1.push_back(w1);
               q0.push_back(w0);
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_vld && dout_ready) begin
            m_vld = 1'b0;
         end
      end
   endtask

   // One clock: scoreboard pop on acceptance, edge, model update, output compare
   task automatic tick();
      if (v1 === 1'b1 && dout_ready) begin
         if (q1.size() == 0) chk("sb_msb_empty", 1, 0);
         else chk("sb_msb_word", dout1, q1.pop_front());
      end
      if (v0 === 1'b1 && dout_ready) begin
         if (q0.size() == 0) chk("sb_lsb_empty", 1, 0);
         else chk("sb_lsb_word", dout0, q0.pop_front());
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("msb_vld",  v1, m_vld);
      chk("lsb_vld",  v0, m_vld);
      chk("msb_ovr",  o1, m_ovr);
      chk("lsb_ovr",  o0, m_ovr);
      chk("msb_busy", b1, m_cnt != 0);
      chk("lsb_busy", b0, m_cnt != 0);
      chk("msb_dout", dout1, m_d1);
      chk("lsb_dout", dout0, m_d0);
   endtask

   task automatic send(input logic b, input logic s, input int gap);
      sin = b; sin_valid = 1'b1; sof = s;
      tick();
      sin_valid = 1'b0; sof = 1'b0;
      repeat (gap) tick();
   endtask

   initial begin
      logic [3:0] w;
      R = 1'b1; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0; dout_ready = 1'b1;
      m_cnt = 0; m_bits = '0; m_vld = 1'b0; m_ovr = 1'b0; m_d1 = '0; m_d0 = '0;
      @(negedge clk);
      tick();
      tick();
      R = 1'b0;
      chk("rst_dout", dout1, 4'd0);
      chk("rst_vld",  v1, 1'b0);
      chk("rst_ovr",  o1, 1'b0);
      chk("rst_busy", b1, 1'b0);

      // 1: MSB-first 1,1,1,0 back to back
      send(1'b1, 1'b1, 0); send(1'b1, 1'b0, 0); send(1'b1, 1'b0, 0); send(1'b0, 1'b0, 0);
      chk("t1_dout", dout1, 4'b1110);
      chk("t1_vld",  v1, 1'b1);
      tick();
      chk("t1_vld_one_cycle", v1, 1'b0);

      // 2: LSB-first 0,1,1,1 with gaps
      send(1'b0, 1'b1, 2);
      chk("t2_busy_gap", b0, 1'b1);
      send(1'b1, 1'b0, 2); send(1'b1, 1'b0, 2);
      chk("t2_busy_late", b0, 1'b1);
      send(1'b1, 1'b0, 0);
      chk("t2_dout", dout0, 4'b1110);
      chk("t2_idle", b0, 1'b0);
      tick();

      // 3: stalled consumer, second word dropped
      dout_ready = 1'b0;
      send(1'b1, 1'b1, 0); send(1'b0, 1'b0, 0); send(1'b1, 1'b0, 0); send(1'b0, 1'b0, 0);
      send(1'b0, 1'b1, 0); send(1'b1, 1'b0, 0); send(1'b0, 1'b0, 0); send(1'b1, 1'b0, 0);
      chk("t3_dout_kept", dout1, 4'b1010);
      chk("t3_vld", v1, 1'b1);
      chk("t3_ovr", o1, 1'b1);
      dout_ready = 1'b1;
      tick();
      chk("t3_vld_drop", v1, 1'b0);
      chk("t3_ovr_sticky", o1, 1'b1);

      // 4: sof discards a partial word
      send(1'b1, 1'b1, 0); send(1'b0, 1'b0, 0);
      send(1'b0, 1'b1, 0); send(1'b0, 1'b0, 0); send(1'b1, 1'b0, 0);
      chk("t4_no_early_vld", v1, 1'b0);
      send(1'b1, 1'b0, 0);
      chk("t4_dout", dout1, 4'b0011);
      chk("t4_lsb_dout", dout0, 4'b1100);

      // 5: reset mid-word
      send(1'b1, 1'b1, 0); send(1'b1, 1'b0, 0); send(1'b0, 1'b0, 0);
      R = 1'b1;
      tick();
      R = 1'b0;
      chk("t5_rst_dout", dout1, 4'd0);
      chk("t5_rst_vld",  v1, 1'b0);
      chk("t5_rst_ovr",  o1, 1'b0);
      chk("t5_rst_busy", b1, 1'b0);
      send(1'b1, 1'b0, 0); send(1'b0, 1'b0, 0); send(1'b0, 1'b0, 0); send(1'b1, 1'b0, 0);
      chk("t5_dout", dout1, 4'b1001);
      tick();

      // 6: back-to-back words, consumer ready whenever a word is shown
      for (int k = 0; k < 6; k++) begin
         w = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) begin
            dout_ready = v1;
            send(w[3-i], i == 0, 0);
         end
      end
      repeat (3) begin
         dout_ready = v1;
         tick();
      end
      chk("t6_msb_drained", q1.size(), 0);
      chk("t6_lsb_drained", q0.size(), 0);
      chk("t6_no_ovr", o1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
Receive-side counterpart of the team's 4-bit load/shift register.
- Takes a bit-serial stream (one bit per qualified clock) and assembles WIDTH-bit parallel words.
- Presents each word on a single-entry output buffer with a valid/ready handshake.
- Sits at the far end of a serial link driven by a parallel-load shift register.
- Reports dropped words via a sticky overrun flag.

Parameters:
WIDTH, 4, word width in bits (legal range 1..32)
MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0]

Ports:
clk  input  1  clock; all state updates on posedge
R  input  1  reset; synchronous, active-high
sin  input  1  serial data bit
sin_valid  input  1  sin is sampled only when this is 1
sof  input  1  start-of-frame; qualified only with sin_valid; marks the current bit as bit 0 of a new word
dout  output  WIDTH  assembled word (registered)
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when dout_valid and dout_ready are both 1 at posedge
overrun  output  1  sticky; a completed word was dropped
busy  output  1  partial word in progress (bit count != 0)

Behaviour:
- Reset is the already-decided scheme: one clock `clk`; reset `R` is synchronous and active-high. R=1 at posedge clears everything.
  - Outputs after reset: dout=0, dout_valid=0, overrun=0, busy=0.
  - Internal state after reset: shift register=0, bit count=0.
  - R has priority over all other inputs. Reset mid-word discards the partial word.
- State machine, two states (count = bits captured so far in the current word):
  - IDLE: count==0. busy=0.
  - SHIFT: 0<count<WIDTH. busy=1.
- Shift rule, applied on each qualified bit (sin_valid=1):
  - MSB_FIRST=1: sh <= {sh[WIDTH-2:0], sin}
  - MSB_FIRST=0: sh <= {sin, sh[WIDTH-1:1]}
  - WIDTH=1: sh <= sin.
- Bit counting:
  - Each qualified bit increments count.
  - When the qualified bit is the WIDTH-th bit, the word completes: count returns to 0 and the state returns to IDLE.
  - sin_valid=0: no change to sh or count. Arbitrary gaps between bits are allowed.
- sof handling:
  - sof=1 with sin_valid=1: any partial word is discarded. The current bit is treated as the first bit of a new word (count becomes 1, or completion if WIDTH=1).
  - sof without sin_valid is ignored.
  - sof on a bit that would have been bit 0 anyway has no side effect.
- Output buffer timing:
  - A completed word is written to dout at the same posedge that captures its last bit.
  - dout_valid=1 from the next cycle. Latency is 1 clk from the last-bit edge to visibility.
- Handshake:
  - Consume: dout_valid & dout_ready at posedge, with no simultaneous completion -> dout_valid <= 0. dout holds its value.
  - Completion while the buffer is empty, or while it is consumed the same cycle -> dout loads the new word, dout_valid=1, no overrun.
  - Completion while dout_valid=1 & dout_ready=0 -> the new word is dropped, the old dout is kept, overrun <= 1.
- overrun is cleared only by R.
- dout and dout_valid never change except by the rules above. dout_ready has no effect when dout_valid=0.

Decomposition:
- Shared package shift_pkg holds:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1
  - RESET_WORD default (0)
- One sub-module, deser_out_buf: the single-entry valid/ready holding register with overrun detection. It takes a word + load strobe and emits dout/dout_valid/overrun.
- The bit counter and shifter live in the top module.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, dout_ready=1: bits 1,1,1,0 on consecutive cycles with sof on the first -> the cycle after the 4th bit shows dout=4'b1110, dout_valid=1 for 1 cycle.
2. WIDTH=4, MSB_FIRST=0: bits 0,1,1,1 with 2-cycle gaps (sin_valid=0) between bits -> dout=4'b1110; busy=1 from after the 1st bit until the 4th bit is captured.
3. dout_ready=0: send word 4'b1010, then word 4'b0101 -> dout stays 4'b1010, dout_valid=1, overrun=1. Raise dout_ready -> dout_valid drops next cycle; overrun stays 1.
4. Send 1,0 then sof with bits 0,0,1,1 -> dout=4'b0011 (partial discarded); no spurious dout_valid before completion.
5. Send 3 bits, assert R for 1 cycle, then send 1,0,0,1 -> dout=4'b1001. All outputs are 0 in the cycle after R.
6. Back-to-back words with dout_ready tied to dout_valid (consume each word as it appears) -> every word is delivered in order, overrun=0.
